d_flip_flop2: RTL and testbench

//   Rising-edge D-type register built as a master-slave pair of level-sensitive latches.
//   The master latch is transparent while clk is low; the slave is transparent while clk is high.
//   It is the basic storage element for datapath pipeline and state registers.

---
 rtl/d_flip_flop2_if.sv | 12 +
 rtl/d_flip_flop2.sv | 28 ++
 tb/tb_d_flip_flop2.sv | 131 +++++++++++++
 3 files changed

// File: rtl/d_flip_flop2_if.sv
// Data/enable bundle for the d_flip_flop2 register: the driver owns en/d, the register owns q/q_n.
interface d_flip_flop2_if #(
  parameter int unsigned WIDTH = 1
);
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;

  modport master (output en, output d, input q, input q_n);
  modport slave  (input en, input d, output q, output q_n);
endinterface

// File: rtl/d_flip_flop2.sv
// Rising-edge D register with synchronous active-low reset and load enable.
// Behaves as a master-slave latch pair, collapsed into one edge-triggered process so the slave always sees the held master value.
module d_flip_flop2 #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  d_flip_flop2_if.slave bus
);

  logic [WIDTH-1:0] m;

  // Master path: the value presented while clk is low and frozen at the rising edge.
  always_comb begin
    m = bus.q;
    if (bus.en) m = bus.d;
  end

  // Slave path: reset wins over enable; nothing changes between rising edges.
  always_ff @(posedge clk) begin
    if (!rst_n) bus.q <= RESET_VAL;
    else        bus.q <= m;
  end

  assign bus.q_n = ~bus.q;

endmodule

// File: tb/tb_d_flip_flop2.sv
// Scoreboard bench for d_flip_flop2: a 1-bit instance and an 8-bit instance with RESET_VAL 8'hA5.
module tb_d_flip_flop2;

  typedef struct {
    int         t;
    string      tag;
    logic [7:0] q;
    logic [7:0] qn;
  } exp_t;

  logic clk;
  logic rst1_n;
  logic rst8_n;
  int   total;
  int   bad;
  exp_t sb1[$];
  exp_t sb8[$];

  d_flip_flop2_if #(.WIDTH(1)) b1 ();
  d_flip_flop2_if #(.WIDTH(8)) b8 ();

  d_flip_flop2 #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (b1)
  );

  d_flip_flop2 #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk   (clk),
    .rst_n (rst8_n),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic at(input int t);
    #(t - int'($time));
  endtask

  task automatic push1(input int t, input string tag, input logic v);
    exp_t e;
    e.t = t; e.tag = tag; e.q = 8'(v); e.qn = 8'(~v);
    sb1.push_back(e);
  endtask

  task automatic push8(input int t, input string tag, input logic [7:0] v);
    exp_t e;
    e.t = t; e.tag = tag; e.q = v; e.qn = ~v;
    sb8.push_back(e);
  endtask

  // Pop every expectation registered for this edge and compare 1 time unit after it.
  always @(posedge clk) begin
    int   e_t;
    exp_t e;
    e_t = int'($time);
    #1;
    while (sb1.size() > 0 && sb1[0].t == e_t) begin
      e = sb1.pop_front();
      chk({e.tag, "_q"},   8'(b1.q),   e.q);
      chk({e.tag, "_qn"},  8'(b1.q_n), 8'(e.qn[0]));
    end
    while (sb8.size() > 0 && sb8[0].t == e_t) begin
      e = sb8.pop_front();
      chk({e.tag, "_q"},  b8.q,   e.q);
      chk({e.tag, "_qn"}, b8.q_n, e.qn);
    end
  end

  // 1-bit instance: reset, capture, glitches, enable hold, reset sync/priority.
  initial begin
    rst1_n = 1'b0; b1.en = 1'b1; b1.d = 1'b1;
    push1(5, "reset", 1'b0);
    at(6);   rst1_n = 1'b1;
    at(10);  b1.d = 1'b1;
    at(13);  b1.d = 1'b0;
    at(14);  b1.d = 1'b1; push1(15, "cap15", 1'b1);
    at(18);  b1.d = 1'b0;
    at(20);  b1.d = 1'b1;
    at(22);  b1.d = 1'b0; push1(25, "glitch_hi", 1'b0);
    at(26);  b1.d = 1'b1;
    at(32);  b1.d = 1'b0; push1(35, "cap35", 1'b0);
    at(39);  b1.d = 1'b1; push1(45, "cap45", 1'b1);
    at(46);  b1.d = 1'b0;
    at(50);  b1.d = 1'b1;
    at(52);  b1.d = 1'b0; push1(55, "glitch_lo", 1'b0);
    at(56);  b1.d = 1'b1; push1(65, "set1", 1'b1);
    at(66);  b1.en = 1'b0; b1.d = 1'b0;
    push1(75, "hold75", 1'b1);
    push1(85, "hold85", 1'b1);
    push1(95, "hold95", 1'b1);
    at(96);  b1.en = 1'b1; push1(105, "en_load", 1'b0);
    at(106); b1.d = 1'b1;
    at(108); rst1_n = 1'b0;
    at(112); rst1_n = 1'b1; push1(115, "rst_pulse", 1'b1);
    at(116); rst1_n = 1'b0; push1(125, "rst_held", 1'b0);
    at(126); rst1_n = 1'b1; b1.d = 1'b1; push1(135, "rst_release", 1'b1);
    at(136); rst1_n = 1'b0; b1.en = 1'b0; push1(145, "rst_prio", 1'b0);
    at(146); rst1_n = 1'b1; b1.en = 1'b1; b1.d = 1'b1; push1(155, "after_prio", 1'b1);
  end

  // 8-bit instance: reset value, load, hold, reset again.
  initial begin
    rst8_n = 1'b0; b8.en = 1'b1; b8.d = 8'h00;
    push8(5, "w8_reset", 8'hA5);
    at(6);  rst8_n = 1'b1; b8.d = 8'h3C; push8(15, "w8_load", 8'h3C);
    at(16); b8.en = 1'b0; b8.d = 8'hFF; push8(25, "w8_hold", 8'h3C);
    at(26); b8.en = 1'b1; push8(35, "w8_ff", 8'hFF);
    at(36); b8.d = 8'h5A; push8(45, "w8_5a", 8'h5A);
    at(46); rst8_n = 1'b0; b8.d = 8'h0F; push8(55, "w8_rst2", 8'hA5);
    at(56); rst8_n = 1'b1; push8(65, "w8_0f", 8'h0F);
  end

  initial begin
    at(200);
    chk("sb1_drain", 8'(sb1.size()), 8'd0);
    chk("sb8_drain", 8'(sb8.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
